// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first payload, even parity, stop bit.
// Each bit is held for CLKS_PER_BIT cycles; tx is registered and idles high.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, ready for a new request
// S_START  | start bit (0) on the line
// S_DATA   | payload bits, shift register LSB on the line
// S_PARITY | even-parity bit on the line
// S_STOP   | stop bit (1) on the line
module serial_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic                parity_q, parity_d;
   logic                tx_q, tx_d;
   logic                done_q, done_d;

   logic                baud_tc;
   logic [DATA_W-1:0]   shreg_shift;

   assign baud_tc     = (baud_q == BAUD_LAST);
   assign shreg_shift = shreg_q >> 1;

   // State register and datapath flops; reset aborts any frame and parks the line high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic; tx_d only moves on acceptance or a bit boundary, so tx never glitches.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      parity_d = parity_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (start) begin
               state_d  = S_START;
               shreg_d  = data_in;
               parity_d = ^data_in;
               tx_d     = 1'b0;
               baud_d   = '0;
               bit_d    = '0;
            end
         end
         S_START: begin
            if (baud_tc) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shreg_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_tc) begin
               baud_d  = '0;
               shreg_d = shreg_shift;
               if (bit_q == BIT_LAST) begin
                  state_d = S_PARITY;
                  tx_d    = parity_q;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shreg_shift[0];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (baud_tc) begin
               state_d = S_STOP;
               baud_d  = '0;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_tc) begin
               state_d = S_IDLE;
               baud_d  = '0;
               tx_d    = 1'b1;
               done_d  = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx    = tx_q;
   assign busy  = (state_q != S_IDLE);
   assign ready = ~busy;
   assign done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: stimulus pushes hand-computed frames into queues,
// a single monitor pops them when a DUT goes busy and checks the line bit by bit.
module tb_serial_frame_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ready, tx, busy, done;

   logic       start2 = 1'b0;
   logic [3:0] data2 = 4'h0;
   logic       ready2, tx2, busy2, done2;

   int checks = 0;
   int errors = 0;

   // frames are {stop, parity, data, start}, so index 0 is the start bit
   logic [10:0] q1[$];
   logic [6:0]  q2[$];

   localparam logic [10:0] F_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
   localparam logic [10:0] F_07 = {1'b1, 1'b1, 8'h07, 1'b0};
   localparam logic [10:0] F_3C = {1'b1, 1'b0, 8'h3C, 1'b0};
   localparam logic [6:0]  F2_B = {1'b1, 1'b1, 4'b1011, 1'b0};

   logic end_req = 1'b0;
   logic end_ack = 1'b0;

   serial_frame_tx u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .data_in (data_in),
      .ready   (ready),
      .tx      (tx),
      .busy    (busy),
      .done    (done)
   );

   serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(2)) u_dut2 (
      .clk     (clk),
      .reset   (reset),
      .start   (start2),
      .data_in (data2),
      .ready   (ready2),
      .tx      (tx2),
      .busy    (busy2),
      .done    (done2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor state
   logic        in1 = 1'b0, bad1 = 1'b0, expdone1 = 1'b0, b2b1 = 1'b0;
   int          cyc1 = 0;
   logic [10:0] fr1 = '1;
   logic        in2 = 1'b0, bad2 = 1'b0, expdone2 = 1'b0;
   int          cyc2 = 0;
   logic [6:0]  fr2 = '1;

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         #1;
         chk("reset_outputs", 32'({tx, ready, busy, done}), 32'(4'b1100));
         chk("reset_outputs2", 32'({tx2, ready2, busy2, done2}), 32'(4'b1100));
         in1 = 1'b0; expdone1 = 1'b0; b2b1 = 1'b0;
         in2 = 1'b0; expdone2 = 1'b0;
      end else begin
         // ---- default instance: 8 data bits, 4 clocks per bit ----
         if (b2b1) begin
            chk("b2b_start", 32'({busy, tx}), 32'(2'b10));
            b2b1 = 1'b0;
         end
         if (expdone1) begin
            chk("done_pulse", 32'({done, ready, busy, tx}), 32'(4'b1101));
            b2b1     = start;
            expdone1 = 1'b0;
         end else begin
            chk("no_stray_done", 32'(done), 32'(0));
         end
         if (!in1 && busy) begin
            if (q1.size() == 0) begin
               chk("unexpected_frame", 32'(busy), 32'(0));
               fr1 = '1;
            end else begin
               fr1 = q1.pop_front();
            end
            in1 = 1'b1; cyc1 = 0; bad1 = 1'b0;
         end
         if (in1) begin
            if (tx !== fr1[cyc1/4] || busy !== 1'b1 || ready !== 1'b0) bad1 = 1'b1;
            if (cyc1 % 4 == 3) begin
               chk($sformatf("frame_bit%0d", cyc1/4), 32'({bad1, tx}), 32'({1'b0, fr1[cyc1/4]}));
               bad1 = 1'b0;
            end
            cyc1++;
            if (cyc1 == 44) begin
               in1 = 1'b0;
               expdone1 = 1'b1;
            end
         end
         // ---- small instance: 4 data bits, 2 clocks per bit ----
         if (expdone2) begin
            chk("done_pulse2", 32'({done2, ready2, busy2, tx2}), 32'(4'b1101));
            expdone2 = 1'b0;
         end else begin
            chk("no_stray_done2", 32'(done2), 32'(0));
         end
         if (!in2 && busy2) begin
            if (q2.size() == 0) begin
               chk("unexpected_frame2", 32'(busy2), 32'(0));
               fr2 = '1;
            end else begin
               fr2 = q2.pop_front();
            end
            in2 = 1'b1; cyc2 = 0; bad2 = 1'b0;
         end
         if (in2) begin
            if (tx2 !== fr2[cyc2/2] || busy2 !== 1'b1 || ready2 !== 1'b0) bad2 = 1'b1;
            if (cyc2 % 2 == 1) begin
               chk($sformatf("frame2_bit%0d", cyc2/2), 32'({bad2, tx2}), 32'({1'b0, fr2[cyc2/2]}));
               bad2 = 1'b0;
            end
            cyc2++;
            if (cyc2 == 14) begin
               in2 = 1'b0;
               expdone2 = 1'b1;
            end
         end
         if (end_req && !end_ack) begin
            chk("queues_drained", 32'(q1.size() + q2.size()), 32'(0));
            chk("monitor_idle", 32'({in1, in2, busy, busy2}), 32'(0));
            end_ack = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) step();
      reset = 1'b1;
      step();

      // A5 after reset release: parity 0
      q1.push_back(F_A5);
      data_in = 8'hA5; start = 1'b1;
      step();
      start = 1'b0; data_in = 8'h00;
      repeat (50) step();

      // 07 with parity 1; mid-frame data change and start pulse must be ignored
      q1.push_back(F_07);
      data_in = 8'h07; start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      data_in = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      repeat (50) step();

      // start held high: two back-to-back 3C frames, accepted in the done cycle
      q1.push_back(F_3C);
      q1.push_back(F_3C);
      data_in = 8'h3C; start = 1'b1;
      step();
      repeat (46) step();
      start = 1'b0;
      repeat (50) step();

      // async reset pulse during data bit 3, then a fresh frame
      q1.push_back(F_A5);
      data_in = 8'hA5; start = 1'b1;
      step();
      start = 1'b0;
      repeat (17) step();
      reset = 1'b0;
      #3;
      reset = 1'b1;
      repeat (10) step();
      q1.push_back(F_07);
      data_in = 8'h07; start = 1'b1;
      step();
      start = 1'b0;
      repeat (50) step();

      // 4-bit, 2-clock instance: 1011 -> parity 1, 14-cycle frame
      q2.push_back(F2_B);
      data2 = 4'b1011; start2 = 1'b1;
      step();
      start2 = 1'b0; data2 = 4'h0;
      repeat (20) step();

      end_req = 1'b1;
      for (int i = 0; i < 10 && !end_ack; i++) step();
      if (!end_ack) begin
         $display("FAIL end_ack timeout actual=0 expected=1");
         $fatal(1, "monitor did not respond");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
